// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer: FSM encoding and default tuning.
package debounce_pkg;

    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

    // Debounce FSM: two stable levels, each with a qualification state for the opposite level
    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_CHK_HIGH = 2'd1,
        ST_HIGH     = 2'd2,
        ST_CHK_LOW  = 2'd3
    } deb_state_e;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous bit; resets to 0.
module sync_chain #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stage;

    // Shift the raw bit through DEPTH flops; only the last one is used downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage <= {stage[DEPTH-2:0], d};
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronises a raw input, accepts a new level only after it has been seen
// DEBOUNCE_CYCLES consecutive cycles, and counts rejected candidate transitions.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = 3,
    parameter int unsigned GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sig_raw,
    input  logic                glitch_clr,
    output logic                sign_out,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GL_MAX   = {GLITCH_W{1'b1}};
    localparam logic [GLITCH_W-1:0] GL_ONE   = GLITCH_W'(1);

    logic             sync_q;
    deb_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             glitch_ev_c;

    sync_chain #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sig_raw),
        .q     (sync_q)
    );

    // A candidate is rejected when the synchronised level reverts during qualification
    assign glitch_ev_c = ((state == ST_CHK_HIGH) && !sync_q) ||
                         ((state == ST_CHK_LOW)  &&  sync_q);

    // Debounce FSM with stability counter; sign_out/busy follow the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_LOW;
            cnt      <= '0;
            sign_out <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_LOW: begin
                    if (sync_q) begin
                        state <= ST_CHK_HIGH;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                ST_CHK_HIGH: begin
                    if (!sync_q) begin
                        state <= ST_LOW;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state    <= ST_HIGH;
                        cnt      <= '0;
                        busy     <= 1'b0;
                        sign_out <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!sync_q) begin
                        state <= ST_CHK_LOW;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                ST_CHK_LOW: begin
                    if (sync_q) begin
                        state <= ST_HIGH;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state    <= ST_LOW;
                        cnt      <= '0;
                        busy     <= 1'b0;
                        sign_out <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state    <= ST_LOW;
                    cnt      <= '0;
                    busy     <= 1'b0;
                    sign_out <= 1'b0;
                end
            endcase
        end
    end

    // Saturating rejected-transition counter; clear takes priority over a same-cycle glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= '0;
        end else if (glitch_clr) begin
            glitch_cnt <= '0;
        end else if (glitch_ev_c && (glitch_cnt != GL_MAX)) begin
            glitch_cnt <= glitch_cnt + GL_ONE;
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed self-checking bench for input_debouncer (default instance plus a GLITCH_W=2 instance).
module tb_input_debouncer;

    logic       clk;
    logic       rst_n;
    logic       sig_raw;
    logic       glitch_clr;
    logic       sign_out;
    logic       busy;
    logic [7:0] glitch_cnt;

    logic       sig_raw_s;
    logic       glitch_clr_s;
    logic       sign_out_s;
    logic       busy_s;
    logic [1:0] glitch_cnt_s;

    int total = 0;
    int bad   = 0;
    int rises = 0;
    int falls = 0;
    logic prev_sign = 1'b0;
    int r0;
    int f0;

    input_debouncer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_raw    (sig_raw),
        .glitch_clr (glitch_clr),
        .sign_out   (sign_out),
        .busy       (busy),
        .glitch_cnt (glitch_cnt)
    );

    input_debouncer #(
        .GLITCH_W (2)
    ) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_raw    (sig_raw_s),
        .glitch_clr (glitch_clr_s),
        .sign_out   (sign_out_s),
        .busy       (busy_s),
        .glitch_cnt (glitch_cnt_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stands in for the downstream edge detector: counts sign_out transitions
    always @(posedge clk or negedge rst_n) begin
        #1;
        if (sign_out && !prev_sign) rises = rises + 1;
        if (!sign_out && prev_sign) falls = falls + 1;
        prev_sign = sign_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        sig_raw      = 1'b1;
        glitch_clr   = 1'b0;
        sig_raw_s    = 1'b0;
        glitch_clr_s = 1'b0;

        // Reset held with input high
        step(3);
        chk("rst_sign", 32'(sign_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_glitch", 32'(glitch_cnt), 0);

        // Release with input high: level accepted on edge 6
        rst_n = 1'b1;
        step(5);
        chk("rel_e5_sign", 32'(sign_out), 0);
        chk("rel_e5_busy", 32'(busy), 1);
        step(1);
        chk("rel_e6_sign", 32'(sign_out), 1);
        chk("rel_e6_busy", 32'(busy), 0);

        // Clean fall from the reset-accepted high
        sig_raw = 1'b0;
        step(5);
        chk("fall0_e5_sign", 32'(sign_out), 1);
        step(1);
        chk("fall0_e6_sign", 32'(sign_out), 0);
        step(3);

        // Clean rise and fall, 10 cycles each
        r0 = rises;
        f0 = falls;
        sig_raw = 1'b1;
        step(2);
        chk("rise_e2_busy", 32'(busy), 0);
        step(1);
        chk("rise_e3_busy", 32'(busy), 1);
        chk("rise_e3_sign", 32'(sign_out), 0);
        step(2);
        chk("rise_e5_sign", 32'(sign_out), 0);
        step(1);
        chk("rise_e6_sign", 32'(sign_out), 1);
        chk("rise_e6_busy", 32'(busy), 0);
        step(4);
        sig_raw = 1'b0;
        step(5);
        chk("fall_e5_sign", 32'(sign_out), 1);
        step(1);
        chk("fall_e6_sign", 32'(sign_out), 0);
        step(4);
        chk("clean_glitch", 32'(glitch_cnt), 0);
        chk("clean_rises", 32'(rises - r0), 1);
        chk("clean_falls", 32'(falls - f0), 1);

        // Three 3-cycle bounces, each rejected
        for (int i = 1; i <= 3; i++) begin
            sig_raw = 1'b1;
            step(3);
            sig_raw = 1'b0;
            step(6);
            chk("bounce_sign", 32'(sign_out), 0);
            chk("bounce_glitch", 32'(glitch_cnt), 32'(i));
        end

        // Bounce then settle high: two 1-cycle pulses rejected, one rise
        r0 = rises;
        sig_raw = 1'b1; step(1);
        sig_raw = 1'b0; step(1);
        sig_raw = 1'b1; step(1);
        sig_raw = 1'b0; step(1);
        sig_raw = 1'b1; step(10);
        chk("settle_sign", 32'(sign_out), 1);
        chk("settle_glitch", 32'(glitch_cnt), 5);
        chk("settle_rises", 32'(rises - r0), 1);

        // Synchronous clear
        glitch_clr = 1'b1;
        step(1);
        glitch_clr = 1'b0;
        chk("clr_glitch", 32'(glitch_cnt), 0);
        chk("clr_sign_kept", 32'(sign_out), 1);

        // Saturation on the 2-bit instance
        for (int i = 1; i <= 5; i++) begin
            sig_raw_s = 1'b1;
            step(1);
            sig_raw_s = 1'b0;
            step(3);
            if (i == 3) chk("sat_at3", 32'(glitch_cnt_s), 3);
        end
        chk("sat_at5", 32'(glitch_cnt_s), 3);
        chk("sat_sign", 32'(sign_out_s), 0);

        // Clear on the same edge as a glitch event
        sig_raw_s = 1'b1;
        step(1);
        sig_raw_s = 1'b0;
        step(2);
        chk("clrglitch_busy", 32'(busy_s), 1);
        glitch_clr_s = 1'b1;
        step(1);
        glitch_clr_s = 1'b0;
        chk("clrglitch_cnt", 32'(glitch_cnt_s), 0);
        chk("clrglitch_busy_after", 32'(busy_s), 0);

        // Reset asserted mid-qualification
        sig_raw = 1'b0;
        step(8);
        chk("pre_rst_sign", 32'(sign_out), 0);
        glitch_clr = 1'b1;
        step(1);
        glitch_clr = 1'b0;
        r0 = rises;
        sig_raw = 1'b1;
        step(4);
        chk("midq_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midq_rst_busy", 32'(busy), 0);
        chk("midq_rst_sign", 32'(sign_out), 0);
        chk("midq_rst_glitch", 32'(glitch_cnt), 0);
        sig_raw = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(10);
        chk("midq_post_sign", 32'(sign_out), 0);
        chk("midq_post_glitch", 32'(glitch_cnt), 0);
        chk("midq_post_rises", 32'(rises - r0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
